// File: rtl/spi_apb_slave_mc_pkg.sv
// Shared definitions for the multi-channel SPI APB register front-end:
// register offsets, FSM states, access classification and strobe helper.
package spi_apb_slave_mc_pkg;

    // Word offsets (paddr[4:2]) inside one channel's register window
    localparam logic [2:0] OFF_CR    = 3'd0;
    localparam logic [2:0] OFF_BR    = 3'd1;
    localparam logic [2:0] OFF_INTER = 3'd2;
    localparam logic [2:0] OFF_SR    = 3'd3;
    localparam logic [2:0] OFF_RINTR = 3'd4;
    localparam logic [2:0] OFF_INTR  = 3'd5;
    localparam logic [2:0] OFF_TFIFO = 3'd6;
    localparam logic [2:0] OFF_RFIFO = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    // What a decoded transfer will do once it is allowed to complete
    typedef enum logic [2:0] {
        ACC_REG_RW = 3'd0,
        ACC_REG_RO = 3'd1,
        ACC_W1C    = 3'd2,
        ACC_TFIFO  = 3'd3,
        ACC_RFIFO  = 3'd4,
        ACC_ERR    = 3'd5
    } access_e;

    // One strobe bit widened into its byte-lane mask
    function automatic logic [7:0] strb_expand_byte(input logic strb);
        return {8{strb}};
    endfunction

endpackage

// File: rtl/spi_apb_slave_mc_if.sv
// APB4 completer-side bus bundle used by the SPI register front-end.
interface spi_apb_slave_mc_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [AW-1:0]     paddr;
    logic [DW-1:0]     pwdata;
    logic [DW/8-1:0]   pstrb;
    logic [DW-1:0]     prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/spi_apb_slave_mc_chan_regs.sv
// One channel's CR/BR/INTER control registers with byte-masked write merge.
module spi_apb_chan_regs #(
    parameter int DW = 32
) (
    input  logic          pclk,
    input  logic          preset,
    input  logic [2:0]    wr_sel_i,   // one-hot: bit0 CR, bit1 BR, bit2 INTER
    input  logic [DW-1:0] wdata_i,
    input  logic [DW-1:0] wmask_i,
    output logic [DW-1:0] cr_o,
    output logic [DW-1:0] br_o,
    output logic [DW-1:0] inter_o
);

    logic [DW-1:0] cr_q, br_q, inter_q;
    logic [DW-1:0] cr_d, br_d, inter_d;

    // Next-state: only the selected register takes the strobed bytes
    always_comb begin
        cr_d    = cr_q;
        br_d    = br_q;
        inter_d = inter_q;
        if (wr_sel_i[0]) begin
            cr_d = (cr_q & ~wmask_i) | (wdata_i & wmask_i);
        end else begin
            cr_d = cr_q;
        end
        if (wr_sel_i[1]) begin
            br_d = (br_q & ~wmask_i) | (wdata_i & wmask_i);
        end else begin
            br_d = br_q;
        end
        if (wr_sel_i[2]) begin
            inter_d = (inter_q & ~wmask_i) | (wdata_i & wmask_i);
        end else begin
            inter_d = inter_q;
        end
    end

    // Register storage with synchronous reset
    always_ff @(posedge pclk) begin
        if (preset) begin
            cr_q    <= '0;
            br_q    <= '0;
            inter_q <= '0;
        end else begin
            cr_q    <= cr_d;
            br_q    <= br_d;
            inter_q <= inter_d;
        end
    end

    assign cr_o    = cr_q;
    assign br_o    = br_q;
    assign inter_o = inter_q;

endmodule

// File: rtl/spi_apb_slave_mc.sv
// APB4 register front-end for N_CH SPI channels. One transfer at a time is
// decoded, optionally stalled on FIFO back-pressure, then answered with a
// single-cycle pready. All side effects are issued on the edge entering RESP.
module spi_apb_slave_mc
    import spi_apb_slave_mc_pkg::*;
#(
    parameter int DW       = 32,
    parameter int AW       = 8,
    parameter int N_CH     = 2,
    parameter int WAIT_MAX = 16
) (
    input  logic                 pclk,
    input  logic                 preset,
    spi_apb_slave_mc_if.slave    apb,
    output logic [N_CH*DW-1:0]   cr_o,
    output logic [N_CH*DW-1:0]   br_o,
    output logic [N_CH*DW-1:0]   inter_o,
    input  logic [N_CH*DW-1:0]   sr_i,
    input  logic [N_CH*DW-1:0]   rintr_i,
    input  logic [N_CH*DW-1:0]   intr_i,
    output logic [N_CH*DW-1:0]   rintr_clr_o,
    output logic [DW-1:0]        tfifo_wdata_o,
    output logic [N_CH-1:0]      tfifo_push_o,
    input  logic [N_CH-1:0]      tfifo_full_i,
    input  logic [N_CH*DW-1:0]   rfifo_rdata_i,
    output logic [N_CH-1:0]      rfifo_pop_o,
    input  logic [N_CH-1:0]      rfifo_empty_i
);

    localparam int CHW  = AW - 5;
    localparam int NB   = DW / 8;
    localparam int CNTW = $clog2(WAIT_MAX + 1);
    localparam logic [CHW:0]    N_CH_W   = (CHW+1)'(N_CH);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WAIT_MAX - 1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    // Decode of the live bus
    logic [2:0]          off_s;
    logic [CHW-1:0]      ch_s;
    logic                setup_s;
    access_e             kind_s;
    logic [DW-1:0]       mask_s;

    // Channel-selected views (live channel in IDLE, latched channel after)
    logic [CHW-1:0]      sel_ch_s;
    logic [N_CH-1:0]     sel_oh_s;
    logic                full_sel_s;
    logic                empty_sel_s;
    logic [DW-1:0]       rfifo_data_sel_s;
    logic [DW-1:0]       cr_sel_s, br_sel_s, inter_sel_s;
    logic [DW-1:0]       sr_sel_s, rintr_sel_s, intr_sel_s;
    logic [DW-1:0]       rd_data_s;
    logic [N_CH*DW-1:0]  clr_val_s;
    logic [N_CH*3-1:0]   wr_sel_s;

    // FSM state and registered outputs
    state_e              state_q;
    logic [CNTW-1:0]     cnt_q;
    logic [CHW-1:0]      ch_q;
    access_e             kind_q;
    logic [DW-1:0]       wdata_q;
    logic [DW-1:0]       prdata_q;
    logic                pready_q;
    logic                pslverr_q;
    logic [N_CH-1:0]     push_q;
    logic [N_CH-1:0]     pop_q;
    logic [N_CH*DW-1:0]  clr_q;
    logic [DW-1:0]       tfifo_wdata_q;

    // Classify the transfer presented on the bus
    always_comb begin
        off_s   = apb.paddr[4:2];
        ch_s    = apb.paddr[AW-1:5];
        setup_s = apb.psel && !apb.penable;
        kind_s  = ACC_ERR;
        if ((apb.paddr[1:0] != 2'b00) || ({1'b0, ch_s} >= N_CH_W)) begin
            kind_s = ACC_ERR;
        end else begin
            case (off_s)
                OFF_CR, OFF_BR, OFF_INTER: kind_s = ACC_REG_RW;
                OFF_SR, OFF_INTR:          kind_s = apb.pwrite ? ACC_ERR : ACC_REG_RO;
                OFF_RINTR:                 kind_s = apb.pwrite ? ACC_W1C : ACC_REG_RO;
                OFF_TFIFO:                 kind_s = (apb.pwrite && (&apb.pstrb)) ? ACC_TFIFO : ACC_ERR;
                OFF_RFIFO:                 kind_s = apb.pwrite ? ACC_ERR : ACC_RFIFO;
                default:                   kind_s = ACC_ERR;
            endcase
        end
    end

    // Pick the addressed channel's signals and form the read data
    always_comb begin
        sel_ch_s         = (state_q == ST_IDLE) ? ch_s : ch_q;
        sel_oh_s         = '0;
        full_sel_s       = 1'b0;
        empty_sel_s      = 1'b0;
        rfifo_data_sel_s = '0;
        cr_sel_s         = '0;
        br_sel_s         = '0;
        inter_sel_s      = '0;
        sr_sel_s         = '0;
        rintr_sel_s      = '0;
        intr_sel_s       = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (sel_ch_s == CHW'(c)) begin
                sel_oh_s[c]      = 1'b1;
                full_sel_s       = tfifo_full_i[c];
                empty_sel_s      = rfifo_empty_i[c];
                rfifo_data_sel_s = rfifo_rdata_i[c*DW +: DW];
                cr_sel_s         = cr_o[c*DW +: DW];
                br_sel_s         = br_o[c*DW +: DW];
                inter_sel_s      = inter_o[c*DW +: DW];
                sr_sel_s         = sr_i[c*DW +: DW];
                rintr_sel_s      = rintr_i[c*DW +: DW];
                intr_sel_s       = intr_i[c*DW +: DW];
            end else begin
                sel_oh_s[c] = 1'b0;
            end
        end
        case (off_s)
            OFF_CR:    rd_data_s = cr_sel_s;
            OFF_BR:    rd_data_s = br_sel_s;
            OFF_INTER: rd_data_s = inter_sel_s;
            OFF_SR:    rd_data_s = sr_sel_s;
            OFF_RINTR: rd_data_s = rintr_sel_s;
            OFF_INTR:  rd_data_s = intr_sel_s;
            default:   rd_data_s = '0;
        endcase
    end

    // Register write strobes, only on the setup cycle of a legal RW write
    always_comb begin
        wr_sel_s = '0;
        for (int c = 0; c < N_CH; c++) begin
            if ((state_q == ST_IDLE) && setup_s && apb.pwrite &&
                (kind_s == ACC_REG_RW) && sel_oh_s[c]) begin
                case (off_s)
                    OFF_CR:    wr_sel_s[c*3 +: 3] = 3'b001;
                    OFF_BR:    wr_sel_s[c*3 +: 3] = 3'b010;
                    OFF_INTER: wr_sel_s[c*3 +: 3] = 3'b100;
                    default:   wr_sel_s[c*3 +: 3] = 3'b000;
                endcase
            end else begin
                wr_sel_s[c*3 +: 3] = 3'b000;
            end
        end
    end

    genvar gb, gc;
    generate
        for (gb = 0; gb < NB; gb++) begin : g_mask
            assign mask_s[gb*8 +: 8] = strb_expand_byte(apb.pstrb[gb]);
        end
        for (gc = 0; gc < N_CH; gc++) begin : g_chan
            spi_apb_chan_regs #(.DW(DW)) u_regs (
                .pclk     (pclk),
                .preset   (preset),
                .wr_sel_i (wr_sel_s[gc*3 +: 3]),
                .wdata_i  (apb.pwdata),
                .wmask_i  (mask_s),
                .cr_o     (cr_o[gc*DW +: DW]),
                .br_o     (br_o[gc*DW +: DW]),
                .inter_o  (inter_o[gc*DW +: DW])
            );
            assign clr_val_s[gc*DW +: DW] = sel_oh_s[gc] ? (apb.pwdata & mask_s) : '0;
        end
    endgenerate

    // Transfer FSM: IDLE decode, STALL on FIFO back-pressure, one-cycle RESP
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            ch_q          <= '0;
            kind_q        <= ACC_ERR;
            wdata_q       <= '0;
            prdata_q      <= '0;
            pready_q      <= 1'b0;
            pslverr_q     <= 1'b0;
            push_q        <= '0;
            pop_q         <= '0;
            clr_q         <= '0;
            tfifo_wdata_q <= '0;
        end else begin
            pready_q <= 1'b0;
            push_q   <= '0;
            pop_q    <= '0;
            clr_q    <= '0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (setup_s) begin
                        ch_q    <= ch_s;
                        kind_q  <= kind_s;
                        wdata_q <= apb.pwdata;
                        case (kind_s)
                            ACC_REG_RW, ACC_REG_RO: begin
                                state_q   <= ST_RESP;
                                pready_q  <= 1'b1;
                                pslverr_q <= 1'b0;
                                prdata_q  <= apb.pwrite ? '0 : rd_data_s;
                            end
                            ACC_W1C: begin
                                state_q   <= ST_RESP;
                                pready_q  <= 1'b1;
                                pslverr_q <= 1'b0;
                                prdata_q  <= '0;
                                clr_q     <= clr_val_s;
                            end
                            ACC_TFIFO: begin
                                if (!full_sel_s) begin
                                    state_q       <= ST_RESP;
                                    pready_q      <= 1'b1;
                                    pslverr_q     <= 1'b0;
                                    prdata_q      <= '0;
                                    push_q        <= sel_oh_s;
                                    tfifo_wdata_q <= apb.pwdata;
                                end else begin
                                    state_q <= ST_STALL;
                                end
                            end
                            ACC_RFIFO: begin
                                if (!empty_sel_s) begin
                                    state_q   <= ST_RESP;
                                    pready_q  <= 1'b1;
                                    pslverr_q <= 1'b0;
                                    prdata_q  <= rfifo_data_sel_s;
                                    pop_q     <= sel_oh_s;
                                end else begin
                                    state_q <= ST_STALL;
                                end
                            end
                            default: begin
                                state_q   <= ST_RESP;
                                pready_q  <= 1'b1;
                                pslverr_q <= 1'b1;
                                prdata_q  <= '0;
                            end
                        endcase
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_STALL: begin
                    if (!apb.psel) begin
                        // Requester abandoned the transfer: drop it silently
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else if ((kind_q == ACC_TFIFO) && !full_sel_s) begin
                        state_q       <= ST_RESP;
                        pready_q      <= 1'b1;
                        pslverr_q     <= 1'b0;
                        prdata_q      <= '0;
                        push_q        <= sel_oh_s;
                        tfifo_wdata_q <= wdata_q;
                        cnt_q         <= '0;
                    end else if ((kind_q == ACC_RFIFO) && !empty_sel_s) begin
                        state_q   <= ST_RESP;
                        pready_q  <= 1'b1;
                        pslverr_q <= 1'b0;
                        prdata_q  <= rfifo_data_sel_s;
                        pop_q     <= sel_oh_s;
                        cnt_q     <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= ST_RESP;
                        pready_q  <= 1'b1;
                        pslverr_q <= 1'b1;
                        prdata_q  <= '0;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign apb.prdata    = prdata_q;
    assign apb.pready    = pready_q;
    assign apb.pslverr   = pslverr_q;
    assign rintr_clr_o   = clr_q;
    assign tfifo_wdata_o = tfifo_wdata_q;
    assign tfifo_push_o  = push_q;
    assign rfifo_pop_o   = pop_q;

endmodule
